// File: rtl/soc_region_map.sv
// soc_region_map: runtime-programmable address-region table.
// Holds NrRules {base, length, attribute} entries with sticky per-rule lock,
// answers lookups through one registered stage and counts missing lookups.
module soc_region_map #(
  parameter int unsigned NrRules      = 8,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned NrSlaves     = 7,
  parameter int unsigned IdxW         = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter int unsigned SlvIdxW      = (NrSlaves > 1) ? $clog2(NrSlaves) : 1,
  parameter logic [NrRules-1:0][AddrWidth-1:0] ResetBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] ResetLength = '0,
  parameter logic [NrRules-1:0][7:0]           ResetAttr   = '0,
  parameter int unsigned DefaultSlave = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW+1:0]      cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic                 lkp_hit_o,
  output logic                 lkp_multi_o,
  output logic [IdxW-1:0]      lkp_idx_o,
  output logic [SlvIdxW-1:0]   lkp_slave_o,
  output logic                 lkp_cached_o,
  output logic                 lkp_exec_o,
  output logic                 lkp_idemp_o,
  output logic [31:0]          miss_cnt_o
);

  localparam logic [SlvIdxW-1:0] DefSlv = SlvIdxW'(DefaultSlave);

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [7:0]           attr_q [NrRules];
  logic [31:0]          miss_cnt_q;

  logic [IdxW-1:0]      cfg_rule;
  logic [1:0]           cfg_field;
  logic                 cfg_is_cnt;
  logic                 cfg_in_range;
  logic [AddrWidth-1:0] sel_base;
  logic [AddrWidth-1:0] sel_len;
  logic [7:0]           sel_attr;
  logic                 cfg_err_d;
  logic [AddrWidth-1:0] cfg_rdata_d;
  logic                 cfg_wr_ok;
  logic                 cnt_clr;

  logic [NrRules-1:0]   match;
  logic                 lkp_accept;
  logic                 win_hit;
  logic                 win_multi;
  logic [IdxW-1:0]      win_idx;
  logic [SlvIdxW-1:0]   win_slave;
  logic                 win_c;
  logic                 win_x;
  logic                 win_i;

  assign cfg_rule     = cfg_addr_i[IdxW+1:2];
  assign cfg_field    = cfg_addr_i[1:0];
  assign cfg_is_cnt   = (cfg_field == 2'd3);
  assign cfg_in_range = (32'(cfg_rule) < NrRules);

  // Select the addressed rule; an out-of-range index reads as an all-zero, unlocked rule.
  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    sel_attr = '0;
    for (int r = 0; r < NrRules; r++) begin
      if (cfg_rule == IdxW'(r)) begin
        sel_base = base_q[r];
        sel_len  = len_q[r];
        sel_attr = attr_q[r];
      end
    end
  end

  // Build the config response: counter field never errors, locked writes and bad indices do.
  always_comb begin
    cfg_err_d   = 1'b0;
    cfg_rdata_d = '0;
    if (cfg_is_cnt) begin
      if (!cfg_we_i) cfg_rdata_d = AddrWidth'(miss_cnt_q);
    end else if (!cfg_in_range) begin
      cfg_err_d = 1'b1;
    end else if (cfg_we_i) begin
      cfg_err_d = sel_attr[7];
    end else begin
      case (cfg_field)
        2'd0:    cfg_rdata_d = sel_base;
        2'd1:    cfg_rdata_d = sel_len;
        default: cfg_rdata_d = AddrWidth'(sel_attr);
      endcase
    end
  end

  assign cfg_wr_ok = cfg_req_i && cfg_we_i && !cfg_is_cnt && cfg_in_range && !sel_attr[7];
  assign cnt_clr   = cfg_req_i && cfg_we_i && cfg_is_cnt;

  // Per-rule match; the end address is formed one bit wider so top-of-space regions never wrap.
  always_comb begin
    match = '0;
    for (int r = 0; r < NrRules; r++) begin
      match[r] = attr_q[r][6] && (len_q[r] != '0) && (lkp_addr_i >= base_q[r]) &&
                 ({1'b0, lkp_addr_i} < ({1'b0, base_q[r]} + {1'b0, len_q[r]}));
    end
  end

  // Priority pick: scanning downward lets the lowest matching index overwrite the rest.
  always_comb begin
    win_idx   = '0;
    win_slave = DefSlv;
    win_c     = 1'b0;
    win_x     = 1'b0;
    win_i     = 1'b0;
    for (int r = NrRules - 1; r >= 0; r--) begin
      if (match[r]) begin
        win_idx   = IdxW'(r);
        win_slave = SlvIdxW'(attr_q[r][2:0]);
        win_c     = attr_q[r][5];
        win_x     = attr_q[r][4];
        win_i     = attr_q[r][3];
      end
    end
  end

  assign win_hit     = |match;
  assign win_multi   = (match & (match - NrRules'(1))) != '0;
  assign lkp_ready_o = !lkp_valid_o || lkp_ready_i;
  assign lkp_accept  = lkp_valid_i && lkp_ready_o;

  // Rule table: reset image from parameters, writes only land on unlocked rules.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NrRules; r++) begin
        base_q[r] <= ResetBase[r];
        len_q[r]  <= ResetLength[r];
        attr_q[r] <= ResetAttr[r];
      end
    end else if (cfg_wr_ok) begin
      for (int r = 0; r < NrRules; r++) begin
        if (cfg_rule == IdxW'(r)) begin
          case (cfg_field)
            2'd0:    base_q[r] <= cfg_wdata_i;
            2'd1:    len_q[r]  <= cfg_wdata_i;
            2'd2:    attr_q[r] <= cfg_wdata_i[7:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Config response register: one-cycle pulse per request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      if (cfg_req_i) begin
        cfg_rdata_o <= cfg_rdata_d;
        cfg_err_o   <= cfg_err_d;
      end
    end
  end

  // Lookup result stage: load on acceptance, hold while stalled, empty once consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lkp_valid_o  <= 1'b0;
      lkp_hit_o    <= 1'b0;
      lkp_multi_o  <= 1'b0;
      lkp_idx_o    <= '0;
      lkp_slave_o  <= DefSlv;
      lkp_cached_o <= 1'b0;
      lkp_exec_o   <= 1'b0;
      lkp_idemp_o  <= 1'b0;
    end else if (lkp_accept) begin
      lkp_valid_o  <= 1'b1;
      lkp_hit_o    <= win_hit;
      lkp_multi_o  <= win_multi;
      lkp_idx_o    <= win_idx;
      lkp_slave_o  <= win_slave;
      lkp_cached_o <= win_c;
      lkp_exec_o   <= win_x;
      lkp_idemp_o  <= win_i;
    end else if (lkp_ready_i) begin
      lkp_valid_o  <= 1'b0;
    end
  end

  // Saturating miss counter; a config clear overrides a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (cnt_clr) begin
      miss_cnt_q <= '0;
    end else if (lkp_accept && !win_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;

endmodule
